rocc_resp_writeback: RTL
========================

Name: rocc_resp_writeback

Overview:
- Writeback stage directly downstream of the RoCC decode/dispatch accelerator and its arithmetic unit.
- Holds the destination-register tags of issued commands in an in-order tag FIFO.
- Accepts 32-bit results over the STB/BUSY handshake and forms RoCC responses (rd, 64-bit data) back to the core.
- Drives the accelerator busy indication to the core.

Parameters:
- TAG_DEPTH, 4: tag FIFO entries; power of two, at least 2.
- DATA_WIDTH, 64: response data width.
- RES_WIDTH, 32: result width from the arithmetic unit.

Ports:
- clk  input  1  clock; all state updates on rising edge
- rst  input  1  asynchronous, active-low reset
- tag_push  input  1  dispatch stage issues a command; pushes a tag
- tag_rd  input  5  destination register of the issued command
- tag_xd  input  1  1 = command expects a response
- tag_sext  input  1  1 = sign-extend the result, 0 = zero-extend it
- tag_full  output  1  tag FIFO full; dispatch must not push
- res_data  input  RES_WIDTH  result from the arithmetic unit
- res_STB  input  1  result strobe
- res_BUSY  output  1  stage cannot accept a result
- resp_valid  output  1  response valid to the core
- resp_ready  input  1  core accepts the response
- resp_rd  output  5  response destination register
- resp_data  output  DATA_WIDTH  response data
- busy  output  1  commands outstanding or a response pending
- err_overflow  output  1  sticky; a push occurred while full
- err_orphan  output  1  sticky; res_STB was seen while the tag FIFO was empty

Behaviour:
- Reset (rst low, asynchronous): FIFO empty, pointers and count 0, state WAIT_RES, resp_valid 0, resp_rd 0, resp_data 0, err flags 0.
  - With the FIFO empty after reset, busy 0, tag_full 0, res_BUSY 1.
- Tag FIFO:
  - Each entry is {rd, xd, sext}.
  - A push is accepted when tag_push=1 and tag_full=0.
  - A push while full is ignored and sets err_overflow. This holds even if a pop occurs in the same cycle; full is evaluated before the pop.
  - A push and a pop in the same non-full cycle: count unchanged, both pointers advance.
  - Pointers wrap modulo TAG_DEPTH; count ranges 0..TAG_DEPTH.
  - tag_full = (count == TAG_DEPTH).
  - A push into an empty FIFO is visible at the head on the next cycle; same-cycle bypass is not required.
- res_BUSY = (state != WAIT_RES) || FIFO empty. This is combinational from registered state.
- Result acceptance: accepted when res_STB=1 and res_BUSY=0. The head tag pops in the same cycle.
- res_STB=1 with FIFO empty sets err_orphan; the result is not consumed and res_BUSY stays 1.
- State machine:
  - WAIT_RES, accepted result with head xd=1:
    - Register resp_rd = head rd.
    - Register resp_data = res_data extended to DATA_WIDTH (sign-extended if head sext=1, else zero-extended).
    - Go to RESP; resp_valid is 1 on the next cycle.
  - WAIT_RES, accepted result with head xd=0: result discarded, tag popped, stay in WAIT_RES, no response.
  - RESP:
    - resp_valid=1 and resp_rd/resp_data held stable until resp_ready=1.
    - On handshake, resp_valid goes 0 on the next cycle and the state returns to WAIT_RES.
    - The next result can be accepted in the cycle after the handshake at the earliest.
- Latency: result accepted at cycle N; resp_valid high at N+1; one response every 2 cycles at best.
- busy = (count != 0) || (state == RESP).
- Reset mid-operation: the pending response and all tags are discarded immediately. No response is issued after reset deassertion.
- Width rule: responses carry exactly RES_WIDTH bits of payload; the upper DATA_WIDTH-RES_WIDTH bits are pure extension.

Test Plan:
- Reset, then idle -> busy=0, res_BUSY=1, resp_valid=0, tag_full=0, both err flags 0.
- Push {rd=5,xd=1,sext=0}, then res_data=32'hFFFF_0001 with res_STB -> next cycle resp_valid=1, resp_rd=5, resp_data=64'h0000_0000_FFFF_0001. Hold resp_ready=0 for 3 cycles: outputs stable. Then resp_ready=1 -> resp_valid=0, busy=0.
- Push {rd=7,xd=1,sext=1}, result 32'h8000_0000 -> resp_data=64'hFFFF_FFFF_8000_0000, resp_rd=7.
- Push tags rd=1 (xd=0), rd=2 (xd=1), rd=3 (xd=1); stream results 10, 20, 30 -> responses only (2,20) then (3,30), in order; res_BUSY=1 during each RESP.
- Push 4 tags (TAG_DEPTH=4) -> tag_full=1. Fifth push, with or without a simultaneous result pop -> ignored, err_overflow=1. Drain all 4 -> tag_full=0, busy=0.
- res_STB with FIFO empty -> err_orphan=1, no response. Push a tag, accept a result, assert rst low while in RESP -> resp_valid=0 immediately, busy=0.

Source files
------------

// File: rtl/rocc_resp_writeback.sv
// rtl/rocc_resp_writeback.sv - RoCC response writeback: in-order tag FIFO plus result-to-response stage
module rocc_resp_writeback #(
  parameter int TAG_DEPTH  = 4,
  parameter int DATA_WIDTH = 64,
  parameter int RES_WIDTH  = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  tag_push,
  input  logic [4:0]            tag_rd,
  input  logic                  tag_xd,
  input  logic                  tag_sext,
  output logic                  tag_full,
  input  logic [RES_WIDTH-1:0]  res_data,
  input  logic                  res_STB,
  output logic                  res_BUSY,
  output logic                  resp_valid,
  input  logic                  resp_ready,
  output logic [4:0]            resp_rd,
  output logic [DATA_WIDTH-1:0] resp_data,
  output logic                  busy,
  output logic                  err_overflow,
  output logic                  err_orphan
);

  localparam int PW = $clog2(TAG_DEPTH);
  localparam logic [PW:0] FULL_CNT = (PW+1)'(TAG_DEPTH);
  localparam logic [0:0] WAIT_RES = 1'b0;
  localparam logic [0:0] RESP     = 1'b1;

  // Each entry packs {rd, xd, sext}
  logic [6:0]    tags [TAG_DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [PW:0]   count;
  logic [0:0]    state;

  logic                  fifo_empty;
  logic                  push_ok;
  logic                  pop;
  logic [6:0]            head;
  logic                  head_xd;
  logic                  head_sext;
  logic [DATA_WIDTH-1:0] ext_data;

  assign fifo_empty = (count == '0);
  assign tag_full   = (count == FULL_CNT);
  assign res_BUSY   = (state != WAIT_RES) || fifo_empty;
  assign resp_valid = (state == RESP);
  assign busy       = !fifo_empty || (state == RESP);

  assign push_ok   = tag_push && !tag_full;
  assign pop       = res_STB && !res_BUSY;
  assign head      = tags[rd_ptr];
  assign head_xd   = head[1];
  assign head_sext = head[0];
  assign ext_data  = {{(DATA_WIDTH-RES_WIDTH){head_sext & res_data[RES_WIDTH-1]}}, res_data};

  always_ff @(posedge clk) begin
    if (push_ok) tags[wr_ptr] <= {tag_rd, tag_xd, tag_sext};
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + PW'(1);
      if (pop)     rd_ptr <= rd_ptr + PW'(1);
      case ({push_ok, pop})
        2'b10:   count <= count + (PW+1)'(1);
        2'b01:   count <= count - (PW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= WAIT_RES;
      resp_rd   <= '0;
      resp_data <= '0;
    end else begin
      case (state)
        WAIT_RES: begin
          // Tags with xd=0 are popped silently; only xd=1 produces a response
          if (pop && head_xd) begin
            resp_rd   <= head[6:2];
            resp_data <= ext_data;
            state     <= RESP;
          end
        end
        default: begin
          if (resp_ready) state <= WAIT_RES;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      err_overflow <= 1'b0;
      err_orphan   <= 1'b0;
    end else begin
      if (tag_push && tag_full) err_overflow <= 1'b1;
      if (res_STB && fifo_empty) err_orphan <= 1'b1;
    end
  end

endmodule
